// File: rtl/bcd_down_timer_pkg.sv
// Shared constants for the two-digit BCD down-timer: FSM encodings, digit limit
// and the preset clamp helper.
package bcd_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit with clamped load and borrow-chained decrement.
// borrow_out flags "this digit and everything below it is zero".
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic       clk,
  input  logic       ncr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_clamp(load_val);
    end else if (dec_en && borrow_in) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!ncr) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = borrow_in && (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with IDLE/RUN/DONE control, STOP priority over
// START, and a one-cycle borrow pulse on the final 01 -> 00 step.
//
//  state   | meaning
//  IDLE    | stopped or after reset; Q holds, waits for START
//  RUN     | counting down one per enabled cycle
//  DONE    | reached 00; Q stays 00 until START, STOP or reset
module bcd_down_timer
  import bcd_down_timer_pkg::*;
(
  input  logic       CLK,
  input  logic       NCR,
  input  logic       EN,
  input  logic       START,
  input  logic       STOP,
  input  logic [3:0] D_TENS,
  input  logic [3:0] D_ONES,
  output logic [3:0] Q_TENS,
  output logic [3:0] Q_ONES,
  output logic       BUSY,
  output logic       DONE,
  output logic       BO
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   bo_q, bo_d;

  logic       load;
  logic       dec_req;
  logic       dec_en;
  logic       preset_zero;
  logic       last_step;
  logic       ones_bo;
  logic       cnt_zero;
  logic [3:0] ones_q, tens_q;

  // cnt_zero comes straight from the digit flops, so it can gate the
  // decrement without forming a combinational loop.
  assign dec_en      = dec_req && !cnt_zero;
  assign preset_zero = (bcd_clamp(D_TENS) == 4'd0) && (bcd_clamp(D_ONES) == 4'd0);
  assign last_step   = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec_req = 1'b0;
    bo_d    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (EN) begin
          dec_req = 1'b1;
          if (last_step) begin
            state_d = ST_DONE;
            bo_d    = 1'b1;
          end
        end
      end
      ST_IDLE, ST_DONE: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (START) begin
          load    = 1'b1;
          state_d = preset_zero ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!NCR) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bo_q    <= bo_d;
    end
  end

  bcd_down_digit u_ones (
    .clk        (CLK),
    .ncr        (NCR),
    .load       (load),
    .load_val   (D_ONES),
    .dec_en     (dec_en),
    .borrow_in  (1'b1),
    .q          (ones_q),
    .borrow_out (ones_bo)
  );

  bcd_down_digit u_tens (
    .clk        (CLK),
    .ncr        (NCR),
    .load       (load),
    .load_val   (D_TENS),
    .dec_en     (dec_en),
    .borrow_in  (ones_bo),
    .q          (tens_q),
    .borrow_out (cnt_zero)
  );

  assign Q_TENS = tens_q;
  assign Q_ONES = ones_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign BO     = bo_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed vector table, corner-case
// sequences and randomized traffic against a decimal-value reference model.
module tb_bcd_down_timer;

  logic       CLK = 1'b0;
  logic       NCR, EN, START, STOP;
  logic [3:0] D_TENS, D_ONES;
  logic [3:0] Q_TENS, Q_ONES;
  logic       BUSY, DONE, BO;

  int vec_cnt = 0;
  int err_cnt = 0;

  bcd_down_timer dut (
    .CLK(CLK), .NCR(NCR), .EN(EN), .START(START), .STOP(STOP),
    .D_TENS(D_TENS), .D_ONES(D_ONES),
    .Q_TENS(Q_TENS), .Q_ONES(Q_ONES), .BUSY(BUSY), .DONE(DONE), .BO(BO)
  );

  always #5 CLK = ~CLK;

  // Reference model: the count as a plain integer 0..99 plus a mode word.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int m_val  = 0;
  int m_mode = M_IDLE;
  bit m_bo   = 1'b0;

  function automatic int clamp9(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  function automatic logic [10:0] model_out();
    logic [3:0] t, o;
    t = 4'(m_val / 10);
    o = 4'(m_val % 10);
    return {t, o, (m_mode == M_RUN), (m_mode == M_DONE), m_bo};
  endfunction

  task automatic model_step();
    m_bo = 1'b0;
    if (!NCR) begin
      m_val  = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (STOP) m_mode = M_IDLE;
      else if (EN) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_mode = M_DONE;
          m_bo   = 1'b1;
        end
      end
    end else begin
      if (STOP) m_mode = M_IDLE;
      else if (START) begin
        m_val  = clamp9(D_TENS) * 10 + clamp9(D_ONES);
        m_mode = (m_val != 0) ? M_RUN : M_DONE;
      end
    end
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got Q=%h%h busy=%b done=%b bo=%b, want Q=%h%h busy=%b done=%b bo=%b",
               name, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {Q_TENS, Q_ONES, BUSY, DONE, BO};
  endfunction

  // Drive one cycle of inputs, clock, advance the model, compare against it.
  task automatic step(input logic ncr, input logic en, input logic start, input logic stop,
                      input logic [3:0] dt, input logic [3:0] dn, input string name);
    NCR = ncr; EN = en; START = start; STOP = stop; D_TENS = dt; D_ONES = dn;
    @(posedge CLK);
    model_step();
    #1;
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    logic       ncr, en, start, stop;
    logic [3:0] dt, dn;
    logic [3:0] et, eo;
    logic       eb, ed, ebo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ncr, input logic en, input logic start, input logic stop,
                     input logic [3:0] dt, input logic [3:0] dn,
                     input logic [3:0] et, input logic [3:0] eo,
                     input logic eb, input logic ed, input logic ebo);
    vec_t v;
    v.ncr = ncr; v.en = en; v.start = start; v.stop = stop; v.dt = dt; v.dn = dn;
    v.et = et; v.eo = eo; v.eb = eb; v.ed = ed; v.ebo = ebo;
    tbl.push_back(v);
  endtask

  initial begin
    int bo_pulses;
    int en_cycles;
    int guard;

    NCR = 1'b0; EN = 1'b0; START = 1'b0; STOP = 1'b0; D_TENS = 4'd0; D_ONES = 4'd0;

    //   ncr en st sp  dt     dn      et   eo   busy done bo
    add(0, 0, 0, 0, 4'h0, 4'h0,  4'd0, 4'd0, 0, 0, 0);  // reset
    add(1, 0, 1, 0, 4'hC, 4'hF,  4'd9, 4'd9, 1, 0, 0);  // clamped load 99
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd9, 4'd8, 1, 0, 0);
    add(1, 1, 0, 1, 4'h0, 4'h0,  4'd9, 4'd8, 0, 0, 0);  // stop holds Q
    add(1, 0, 1, 0, 4'h0, 4'h0,  4'd0, 4'd0, 0, 1, 0);  // preset 00 -> DONE, no BO
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd0, 0, 1, 0);  // no underflow in DONE
    add(1, 0, 1, 1, 4'h0, 4'h5,  4'd0, 4'd0, 0, 0, 0);  // STOP wins in DONE -> IDLE
    add(1, 0, 1, 0, 4'h0, 4'h5,  4'd0, 4'd5, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd4, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd3, 1, 0, 0);
    add(1, 1, 0, 1, 4'h0, 4'h0,  4'd0, 4'd3, 0, 0, 0);  // stop at 03
    add(1, 0, 1, 1, 4'h0, 4'h5,  4'd0, 4'd3, 0, 0, 0);  // start+stop in IDLE: no load
    add(1, 0, 1, 0, 4'h0, 4'h5,  4'd0, 4'd5, 1, 0, 0);  // reload
    add(1, 0, 1, 0, 4'h9, 4'h9,  4'd0, 4'd5, 1, 0, 0);  // START in RUN ignored
    add(1, 1, 1, 0, 4'h9, 4'h9,  4'd0, 4'd4, 1, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'h0,  4'd0, 4'd4, 1, 0, 0);  // EN=0 holds
    add(1, 0, 0, 1, 4'h0, 4'h0,  4'd0, 4'd4, 0, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'h9,  4'd0, 4'd9, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd8, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd7, 1, 0, 0);
    add(0, 1, 1, 0, 4'h5, 4'h5,  4'd0, 4'd0, 0, 0, 0);  // reset at 07 with START
    add(1, 0, 1, 0, 4'h0, 4'h1,  4'd0, 4'd1, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd0, 0, 1, 1);  // 01 -> 00 with BO
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd0, 4'd0, 0, 1, 0);  // BO only one cycle
    add(1, 0, 0, 1, 4'h0, 4'h0,  4'd0, 4'd0, 0, 0, 0);  // STOP in DONE -> IDLE
    add(1, 0, 1, 0, 4'h4, 4'h0,  4'd4, 4'd0, 1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'h0,  4'd3, 4'd9, 1, 0, 0);  // 40 -> 39 borrow

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ncr, tbl[i].en, tbl[i].start, tbl[i].stop, tbl[i].dt, tbl[i].dn,
           $sformatf("vec%0d_model", i));
      check($sformatf("vec%0d_table", i), dut_out(),
            {tbl[i].et, tbl[i].eo, tbl[i].eb, tbl[i].ed, tbl[i].ebo});
    end

    // Preset 12 with continuous EN: twelve decrements, one BO pulse.
    step(0, 0, 0, 0, 4'h0, 4'h0, "p12_reset");
    step(1, 0, 1, 0, 4'h1, 4'h2, "p12_load");
    bo_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 4'h0, 4'h0, $sformatf("p12_dec%0d", i));
      if (BO) bo_pulses++;
    end
    check("p12_final", dut_out(), {4'd0, 4'd0, 1'b0, 1'b1, 1'b1});
    step(1, 1, 0, 0, 4'h0, 4'h0, "p12_after");
    if (BO) bo_pulses++;
    check("p12_bo_count", 11'(bo_pulses), 11'd1);

    // Preset 30 with EN toggling: exactly 30 enabled cycles reach DONE.
    step(1, 0, 0, 1, 4'h0, 4'h0, "p30_idle");
    step(1, 0, 1, 0, 4'h3, 4'h0, "p30_load");
    en_cycles = 0;
    guard = 0;
    while (!DONE && guard < 200) begin
      step(1, guard[0] == 1'b0, 0, 0, 4'h0, 4'h0, $sformatf("p30_c%0d", guard));
      if (guard[0] == 1'b0) en_cycles++;
      guard++;
    end
    check("p30_done", {10'd0, DONE}, 11'd1);
    check("p30_en_cycles", 11'(en_cycles), 11'd30);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
